// File: rtl/xor_nn_pkg.sv
// Shared definitions for the XOR network: weight geometry, loader FSM states
// and the known-good default weights that the inference datapath also uses.
package xor_nn_pkg;

   localparam int DATA_W      = 8;
   localparam int NUM_WEIGHTS = 9;
   localparam int NUM_W1      = 6;
   localparam int NUM_W2      = 3;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      DRAIN
   } load_state_t;

   // Row-major w1 (k = r*2+c) followed by w2 (index r): a working XOR solution.
   localparam int W1_DEFAULT [NUM_W1] = '{0, -1, 1, 1, 1, 1};
   localparam int W2_DEFAULT [NUM_W2] = '{0, 1, -2};

endpackage

// File: rtl/xor_nn_weight_loader.sv
// Streams a 9-beat weight frame into a shadow bank and commits it atomically
// to the w1/w2 outputs once a well-formed frame has been fully received.
module xor_nn_weight_loader
   import xor_nn_pkg::*;
#(
   parameter int DATA_W      = xor_nn_pkg::DATA_W,
   parameter int NUM_WEIGHTS = xor_nn_pkg::NUM_WEIGHTS
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   s_valid,
   output logic                   s_ready,
   input  logic [DATA_W-1:0]      s_data,
   input  logic                   s_last,
   output logic [6*DATA_W-1:0]    w1_flat,
   output logic [3*DATA_W-1:0]    w2_flat,
   output logic                   weights_updated,
   output logic                   busy,
   output logic                   frame_err,
   output logic [7:0]             err_count
);

   localparam int         BANK_W   = NUM_WEIGHTS * DATA_W;
   localparam logic [3:0] LAST_IDX = 4'(NUM_WEIGHTS - 1);

   function automatic logic [BANK_W-1:0] default_bank();
      logic [BANK_W-1:0] b;
      b = '0;
      for (int k = 0; k < NUM_W1; k++) begin
         b[k*DATA_W +: DATA_W] = DATA_W'(W1_DEFAULT[k]);
      end
      for (int r = 0; r < NUM_W2; r++) begin
         b[(NUM_W1+r)*DATA_W +: DATA_W] = DATA_W'(W2_DEFAULT[r]);
      end
      return b;
   endfunction

   localparam logic [BANK_W-1:0] DEFAULT_BANK = default_bank();

   load_state_t       state_q, state_d;
   logic [3:0]        idx_q, idx_d;
   logic [BANK_W-1:0] shadow_q;
   logic [BANK_W-1:0] bank_q;
   logic              beat;
   logic              shadow_we;
   logic              commit;
   logic              frame_bad;
   logic              commit_pend_q;

   assign s_ready = 1'b1;
   assign beat    = s_valid & s_ready;
   assign busy    = (state_q != IDLE);
   assign w1_flat = bank_q[NUM_W1*DATA_W-1:0];
   assign w2_flat = bank_q[BANK_W-1:NUM_W1*DATA_W];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         idx_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   // IDLE and LOAD share the beat handling; IDLE simply always sits at index 0.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      shadow_we = 1'b0;
      commit    = 1'b0;
      frame_bad = 1'b0;
      case (state_q)
         IDLE, LOAD: begin
            if (beat) begin
               shadow_we = 1'b1;
               if (idx_q == LAST_IDX) begin
                  idx_d = 4'd0;
                  if (s_last) begin
                     commit  = 1'b1;
                     state_d = IDLE;
                  end else begin
                     frame_bad = 1'b1;
                     state_d   = DRAIN;
                  end
               end else if (s_last) begin
                  frame_bad = 1'b1;
                  idx_d     = 4'd0;
                  state_d   = IDLE;
               end else begin
                  idx_d   = idx_q + 4'd1;
                  state_d = LOAD;
               end
            end
         end
         DRAIN: begin
            if (beat && s_last) begin
               state_d = IDLE;
               idx_d   = 4'd0;
            end
         end
         default: begin
            state_d = IDLE;
            idx_d   = 4'd0;
         end
      endcase
   end

   // The committed bank copies the shadow one edge after the final beat lands,
   // so a new frame's beat 0 written on that same edge never leaks through.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         shadow_q        <= DEFAULT_BANK;
         bank_q          <= DEFAULT_BANK;
         commit_pend_q   <= 1'b0;
         weights_updated <= 1'b0;
         frame_err       <= 1'b0;
         err_count       <= 8'd0;
      end else begin
         for (int k = 0; k < NUM_WEIGHTS; k++) begin
            if (shadow_we && idx_q == 4'(k)) begin
               shadow_q[k*DATA_W +: DATA_W] <= s_data;
            end
         end
         commit_pend_q   <= commit;
         weights_updated <= commit_pend_q;
         if (commit_pend_q) begin
            bank_q <= shadow_q;
         end
         if (commit) begin
            frame_err <= 1'b0;
         end else if (frame_bad) begin
            frame_err <= 1'b1;
         end
         if (frame_bad && err_count != 8'hFF) begin
            err_count <= err_count + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_xor_nn_weight_loader.sv
// Scoreboard bench for the weight loader: stimulus pushes expected commits,
// a negedge monitor pops and compares them whenever weights_updated fires.
module tb_xor_nn_weight_loader;

   logic        clk;
   logic        reset_n;
   logic        s_valid;
   logic        s_ready;
   logic [7:0]  s_data;
   logic        s_last;
   logic [47:0] w1_flat;
   logic [23:0] w2_flat;
   logic        weights_updated;
   logic        busy;
   logic        frame_err;
   logic [7:0]  err_count;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [71:0] sb_q [$];
   int          pulse_cyc [$];

   localparam logic [71:0] DEFAULTS = {24'hFE_01_00, 48'h01_01_01_01_FF_00};

   int F1 [9] = '{2, -3, 4, 5, -6, 7, 1, -1, 3};
   int F2 [9] = '{10, -20, 30, -40, 50, -60, 70, -80, 90};
   int F3 [9] = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
   int F4 [9] = '{-1, -2, -3, -4, -5, -6, -7, -8, -9};
   int F5 [9] = '{11, 12, 13, 14, 15, 16, 17, 18, 19};

   xor_nn_weight_loader dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .s_valid         (s_valid),
      .s_ready         (s_ready),
      .s_data          (s_data),
      .s_last          (s_last),
      .w1_flat         (w1_flat),
      .w2_flat         (w2_flat),
      .weights_updated (weights_updated),
      .busy            (busy),
      .frame_err       (frame_err),
      .err_count       (err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [71:0] pack_frame(input int f [9]);
      logic [71:0] r;
      r = '0;
      for (int k = 0; k < 9; k++) r[k*8 +: 8] = 8'(f[k]);
      return r;
   endfunction

   task automatic check_output(input string name, input logic [71:0] act, input logic [71:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_stimulus(input int data, input logic last);
      s_valid = 1'b1;
      s_data  = 8'(data);
      s_last  = last;
      tick();
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic send_frame(input int f [9]);
      for (int i = 0; i < 9; i++) apply_stimulus(f[i], (i == 8));
   endtask

   // Monitor: every commit pulse must match the oldest expected frame.
   always @(negedge clk) begin
      if (reset_n === 1'b1 && weights_updated === 1'b1) begin
         pulse_cyc.push_back(cyc);
         if (sb_q.size() == 0) begin
            check_output("unexpected_commit", 72'd1, 72'd0);
         end else begin
            check_output("commit_bank", {w2_flat, w1_flat}, sb_q.pop_front());
         end
      end
   end

   initial begin
      int n;
      s_valid = 1'b0;
      s_data  = 8'd0;
      s_last  = 1'b0;
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;

      @(negedge clk);
      check_output("reset_bank", {w2_flat, w1_flat}, DEFAULTS);
      check_output("reset_updated", weights_updated, 0);
      check_output("reset_err_count", err_count, 0);
      check_output("reset_frame_err", frame_err, 0);
      check_output("reset_busy", busy, 0);
      check_output("s_ready", s_ready, 1);
      tick();

      // Gapped good frame
      sb_q.push_back(pack_frame(F1));
      for (int i = 0; i < 8; i++) begin
         apply_stimulus(F1[i], 1'b0);
         @(negedge clk);
         check_output("gap_hold_bank", {w2_flat, w1_flat}, DEFAULTS);
         if (i == 3) check_output("gap_busy", busy, 1);
         tick();
      end
      apply_stimulus(F1[8], 1'b1);
      @(negedge clk);
      check_output("pre_commit_updated", weights_updated, 0);
      check_output("pre_commit_bank", {w2_flat, w1_flat}, DEFAULTS);
      @(negedge clk);
      check_output("commit_updated", weights_updated, 1);
      check_output("commit_w1", w1_flat, pack_frame(F1) & 72'hFFFF_FFFF_FFFF);
      check_output("commit_w2", w2_flat, pack_frame(F1) >> 48);
      @(negedge clk);
      check_output("pulse_one_cycle", weights_updated, 0);
      check_output("idle_busy", busy, 0);
      tick();

      // Early s_last on beat 4
      for (int i = 0; i < 3; i++) apply_stimulus(9, 1'b0);
      apply_stimulus(9, 1'b1);
      @(negedge clk);
      check_output("early_frame_err", frame_err, 1);
      check_output("early_err_count", err_count, 1);
      check_output("early_busy", busy, 0);
      check_output("early_bank", {w2_flat, w1_flat}, pack_frame(F1));
      tick();
      sb_q.push_back(pack_frame(F2));
      send_frame(F2);
      repeat (3) tick();
      check_output("recover_frame_err", frame_err, 0);
      check_output("recover_err_count", err_count, 1);
      check_output("recover_bank", {w2_flat, w1_flat}, pack_frame(F2));

      // Missing s_last: 12 beats, last only on beat 12
      n = pulse_cyc.size();
      for (int i = 0; i < 9; i++) apply_stimulus(F3[i], 1'b0);
      @(negedge clk);
      check_output("drain_busy", busy, 1);
      check_output("drain_err_count", err_count, 2);
      check_output("drain_frame_err", frame_err, 1);
      tick();
      apply_stimulus(33, 1'b0);
      apply_stimulus(44, 1'b0);
      @(negedge clk);
      check_output("drain_busy_b11", busy, 1);
      tick();
      apply_stimulus(55, 1'b1);
      @(negedge clk);
      check_output("drain_exit_busy", busy, 0);
      tick();
      repeat (3) tick();
      check_output("drain_no_commit", pulse_cyc.size(), n);
      check_output("drain_err_once", err_count, 2);
      check_output("drain_bank", {w2_flat, w1_flat}, pack_frame(F2));

      // Back-to-back frames
      n = pulse_cyc.size();
      sb_q.push_back(pack_frame(F3));
      sb_q.push_back(pack_frame(F4));
      send_frame(F3);
      send_frame(F4);
      repeat (3) tick();
      check_output("b2b_pulses", pulse_cyc.size(), n + 2);
      if (pulse_cyc.size() >= n + 2)
         check_output("b2b_spacing", pulse_cyc[n+1] - pulse_cyc[n], 9);
      check_output("b2b_bank", {w2_flat, w1_flat}, pack_frame(F4));
      check_output("b2b_frame_err", frame_err, 0);

      // Single-beat frames drive err_count to saturation
      for (int i = 0; i < 252; i++) apply_stimulus(i, 1'b1);
      @(negedge clk);
      check_output("sat_254", err_count, 254);
      check_output("single_busy", busy, 0);
      tick();
      for (int i = 0; i < 5; i++) apply_stimulus(i, 1'b1);
      @(negedge clk);
      check_output("sat_255", err_count, 255);
      check_output("sat_frame_err", frame_err, 1);
      check_output("sat_bank", {w2_flat, w1_flat}, pack_frame(F4));
      tick();

      // Reset mid-frame
      for (int i = 0; i < 5; i++) apply_stimulus(-100 + i, 1'b0);
      reset_n = 1'b0;
      #2;
      check_output("midrst_bank", {w2_flat, w1_flat}, DEFAULTS);
      check_output("midrst_busy", busy, 0);
      check_output("midrst_err_count", err_count, 0);
      check_output("midrst_frame_err", frame_err, 0);
      tick();
      reset_n = 1'b1;
      tick();
      sb_q.push_back(pack_frame(F5));
      for (int i = 0; i < 8; i++) apply_stimulus(F5[i], 1'b0);
      @(negedge clk);
      check_output("midrst_hold_bank", {w2_flat, w1_flat}, DEFAULTS);
      tick();
      apply_stimulus(F5[8], 1'b1);
      repeat (3) tick();
      check_output("midrst_commit_bank", {w2_flat, w1_flat}, pack_frame(F5));
      check_output("total_pulses", pulse_cyc.size(), 5);
      check_output("sb_drain", sb_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/xor_nn_weight_loader.md
XOR_NN_WEIGHT_LOADER -- requirements
Module: xor_nn_weight_loader

Interface
REQ-001 Parameter DATA_W: default 8; signed weight width in bits.
REQ-002 Parameter NUM_WEIGHTS: default 9; beats per weight frame, i.e. 6 w1 plus 3 w2.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 s_valid  input  1  upstream beat valid.
REQ-006 s_ready  output  1  loader can accept a beat.
REQ-007 s_data  input  DATA_W  signed weight value, two's complement.
REQ-008 s_last  input  1  marks the final beat of a frame.
REQ-009 w1_flat  output  6*DATA_W  committed w1 weights; index k = r*2+c occupies bits [k*DATA_W +: DATA_W].
REQ-010 w2_flat  output  3*DATA_W  committed w2 weights; index r occupies bits [r*DATA_W +: DATA_W].
REQ-011 weights_updated  output  1  one-cycle pulse on each commit.
REQ-012 busy  output  1  a frame is partially received.
REQ-013 frame_err  output  1  sticky; set on a malformed frame, cleared by the next good commit.
REQ-014 err_count  output  8  count of malformed frames; saturates at 255.

Function
REQ-015 A beat SHALL transfer only in a cycle where s_valid and s_ready are both 1.
REQ-016 Beat order within a frame SHALL be w1[0][0], w1[0][1], w1[1][0], w1[1][1], w1[2][0], w1[2][1], w2[0][0], w2[1][0], w2[2][0].
REQ-017 The FSM SHALL have three states: IDLE, LOAD, DRAIN.
REQ-018 s_ready SHALL be 1 in every state; the loader never back-pressures.
REQ-019 A 4-bit beat index SHALL select the target shadow register, counting 0..NUM_WEIGHTS-1.
- IDLE to LOAD on the first accepted beat without s_last.
- The index resets to 0 on every return to IDLE.
REQ-020 Accepted beats SHALL write shadow registers only; the w1_flat and w2_flat outputs SHALL NOT change mid-frame.
REQ-021 Good frame (beat index 8 accepted with s_last=1):
- Shadow registers, including the beat-8 data, are copied to the outputs on the next rising edge.
- weights_updated=1 for exactly that cycle.
- frame_err clears; the FSM returns to IDLE.
REQ-022 A beat accepted in the commit cycle SHALL start a new frame at index 0, so back-to-back frames lose no cycles.
REQ-023 Early s_last (s_last=1 on index < 8):
- Outputs are unchanged; frame_err sets; err_count increments.
- The FSM returns to IDLE.
REQ-024 Missing s_last (index 8 accepted with s_last=0):
- frame_err sets; err_count increments; the FSM enters DRAIN.
- DRAIN discards beats until a beat with s_last=1 is accepted, then returns to IDLE with no commit.
REQ-025 busy SHALL be 1 in LOAD and DRAIN, and 0 in IDLE.
REQ-026 A single-beat frame (s_last=1 on index 0) SHALL be treated as early s_last.
REQ-027 err_count SHALL hold at 255 on further errors.
REQ-028 Idle cycles (s_valid=0) mid-frame SHALL NOT advance the index or affect state.

Reset
REQ-029 Asserting reset_n=0 SHALL, asynchronously and at any point including mid-frame, force:
- FSM=IDLE, index=0, weights_updated=0, busy=0, frame_err=0, err_count=0.
- Shadow registers equal to the defaults.
REQ-030 Reset defaults for w1 (row-major) SHALL be 0, -1, 1, 1, 1, 1; for w2 they SHALL be 0, 1, -2. This is the known-good XOR solution.
REQ-031 A frame interrupted by reset SHALL be discarded entirely; the first beat after deassertion is index 0.

Structure
REQ-032 Package xor_nn_pkg SHALL hold:
- DATA_W and NUM_WEIGHTS;
- the FSM state type;
- the default weight constants shared with the inference datapath.
REQ-033 The block SHALL be a single module with no sub-module; the shadow and committed banks are plain register arrays.

Verification
REQ-034 Reset: pulse reset_n low, then release -> w1_flat decodes to 0,-1,1,1,1,1; w2_flat to 0,1,-2; weights_updated=0; err_count=0.
REQ-035 Good frame: stream 2,-3,4,5,-6,7,1,-1,3 (s_last on the 9th beat), with s_valid gapped every other cycle -> outputs unchanged until one cycle after beat 9, then equal to that stream; exactly one weights_updated pulse.
REQ-036 Early s_last on beat 4 -> outputs unchanged; frame_err=1; err_count=1; a following good frame commits and clears frame_err.
REQ-037 Missing s_last: 12 beats with s_last only on beat 12 -> no commit; err_count increments once; busy falls after beat 12.
REQ-038 Back-to-back: two good frames with s_valid continuously high -> two weights_updated pulses 9 cycles apart; final outputs equal frame 2.
REQ-039 Reset mid-frame: reset after 5 beats, then a good frame -> defaults hold until the commit; the committed values equal the new frame only.
